// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for seq_chunk_adder. The master side issues
// operations and the slave side (the adder) returns the results.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] Z;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, x, y,
    input  Z, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, x, y,
    output Z, cout, ovf, busy, done
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair goes through one
// CHUNK-bit ripple slice, LSB chunk first. The carry is held in a register
// between chunks. WIDTH must be a multiple of CHUNK.

// One CHUNK-bit ripple-carry slice. It also exposes the carry into its top
// bit so that signed overflow can be taken on the last chunk.
module seq_chunk_adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cmsb,
  output logic             o_cout
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cmsb = w_c[CHUNK-1];
  assign o_cout = w_c[CHUNK];
endmodule

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            reset,
  seq_chunk_adder_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;

  // Operands and mode are captured on start, so input changes during RUN
  // have no effect.
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_sub;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_part;

  // Results visible to the user. They change only at completion, so they
  // never show partially computed chunks.
  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;

  logic [CHUNK-1:0] w_xk;
  logic [CHUNK-1:0] w_yk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cmsb;
  logic             w_cout;
  logic [WIDTH-1:0] w_part;
  logic             w_busy;
  logic             w_accept;
  logic             w_last;
  int               w_base;

  // Select chunk k of each operand. In subtract mode y is inverted and the
  // carry was seeded with 1, which gives x + ~y + 1.
  always_comb begin
    w_base = int'(r_cnt) * CHUNK;
    w_xk   = r_x[w_base +: CHUNK];
    w_yk   = r_y[w_base +: CHUNK] ^ {CHUNK{r_sub}};
  end

  seq_chunk_adder_slice #(.CHUNK(CHUNK)) u_slice (
    .i_a    (w_xk),
    .i_b    (w_yk),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cmsb (w_cmsb),
    .o_cout (w_cout)
  );

  // Partial result with the current chunk merged in. It doubles as the final
  // Z on the last chunk.
  always_comb begin
    w_part                  = r_part;
    w_part[w_base +: CHUNK] = w_sum;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = RUN;
      RUN:  if (w_last)    w_next = IDLE;
    endcase
  end

  // FSM outputs. A start request is honoured only while idle.
  always_comb begin
    w_busy   = (r_state == RUN);
    w_accept = (r_state == IDLE) && bus.start;
    w_last   = (r_state == RUN) && (r_cnt == CW'(N - 1));
  end

  // Datapath: capture operands on accept, then step one chunk per clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_part  <= '0;
      r_z     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_x     <= bus.x;
        r_y     <= bus.y;
        r_sub   <= bus.sub;
        r_carry <= bus.sub;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_part  <= w_part;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          // Overflow is the carry into the MSB XOR the carry out of the MSB.
          r_z    <= w_part;
          r_cout <= w_cout;
          r_ovf  <= w_cmsb ^ w_cout;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end
      end
    end
  end

  assign bus.Z    = r_z;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.busy = w_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder. It runs three instances (16/4, 8/8 and 32/4)
// through directed and random operations. Results are checked against an
// arithmetic reference model.
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [63:0] prev_z [3];

  seq_chunk_adder_if #(.WIDTH(16)) b16 ();
  seq_chunk_adder_if #(.WIDTH(8))  b8  ();
  seq_chunk_adder_if #(.WIDTH(32)) b32 ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .reset(reset), .bus(b16));
  seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .reset(reset), .bus(b8));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u32 (.clk(clk), .reset(reset), .bus(b32));

  always #5 clk = ~clk;

  function automatic int wid(input int sel);
    case (sel)
      0:       return 16;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int chk_w(input int sel);
    case (sel)
      0:       return 4;
      1:       return 8;
      default: return 4;
    endcase
  endfunction

  // Reference: plain modular and signed integer arithmetic
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input bit s, output logic [63:0] z, output logic c,
                                output logic o);
    longint p2, ua, ub, sa, sb, r, sr;
    p2 = longint'(1) << w;
    ua = longint'(a) & (p2 - 1);
    ub = longint'(b) & (p2 - 1);
    sa = (ua >= p2 / 2) ? ua - p2 : ua;
    sb = (ub >= p2 / 2) ? ub - p2 : ub;
    if (s) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= p2);
      sr = sa + sb;
    end
    z = 64'(r & (p2 - 1));
    o = (sr >= p2 / 2) || (sr < -(p2 / 2));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input bit st, input logic [63:0] a,
                       input logic [63:0] b, input bit s);
    case (sel)
      0: begin b16.start = st; b16.x = a[15:0]; b16.y = b[15:0]; b16.sub = s; end
      1: begin b8.start  = st; b8.x  = a[7:0];  b8.y  = b[7:0];  b8.sub  = s; end
      default: begin b32.start = st; b32.x = a[31:0]; b32.y = b[31:0]; b32.sub = s; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [63:0] z, output logic c,
                        output logic o, output logic bz, output logic d);
    case (sel)
      0: begin z = 64'(b16.Z); c = b16.cout; o = b16.ovf; bz = b16.busy; d = b16.done; end
      1: begin z = 64'(b8.Z);  c = b8.cout;  o = b8.ovf;  bz = b8.busy;  d = b8.done;  end
      default: begin
        z = 64'(b32.Z); c = b32.cout; o = b32.ovf; bz = b32.busy; d = b32.done;
      end
    endcase
  endtask

  // Issue one operation, optionally re-pulse start mid-flight with other
  // operands, and check every cycle up to and including the done cycle.
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input bit s, input string tag, input int pulse_at);
    int          n;
    logic [63:0] ez, z;
    logic        ec, eo, c, o, bz, d;
    n = wid(sel) / chk_w(sel);
    model(wid(sel), a, b, s, ez, ec, eo);
    drive(sel, 1'b1, a, b, s);
    @(posedge clk); #1;
    drive(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    sample(sel, z, c, o, bz, d);
    chk($sformatf("%s.busy_start", tag), 64'(bz), 64'(1));
    chk($sformatf("%s.done_start", tag), 64'(d), 64'(0));
    for (int i = 1; i <= n; i++) begin
      if (i == pulse_at)
        drive(sel, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      if (i == pulse_at) drive(sel, 1'b0, 64'd0, 64'd0, 1'b0);
      sample(sel, z, c, o, bz, d);
      if (i < n) begin
        chk($sformatf("%s.busy%0d", tag, i), 64'(bz), 64'(1));
        chk($sformatf("%s.done%0d", tag, i), 64'(d), 64'(0));
        chk($sformatf("%s.zhold%0d", tag, i), z, prev_z[sel]);
      end else begin
        chk($sformatf("%s.done", tag), 64'(d), 64'(1));
        chk($sformatf("%s.busy_end", tag), 64'(bz), 64'(0));
        chk($sformatf("%s.Z", tag), z, ez);
        chk($sformatf("%s.cout", tag), 64'(c), 64'(ec));
        chk($sformatf("%s.ovf", tag), 64'(o), 64'(eo));
        prev_z[sel] = ez;
      end
    end
  endtask

  // Directed literal check of the held result
  task automatic chk_lit(input int sel, input string tag, input logic [63:0] ez,
                         input logic ec, input logic eo);
    logic [63:0] z;
    logic        c, o, bz, d;
    sample(sel, z, c, o, bz, d);
    chk($sformatf("%s.litZ", tag), z, ez);
    chk($sformatf("%s.litC", tag), 64'(c), 64'(ec));
    chk($sformatf("%s.litO", tag), 64'(o), 64'(eo));
  endtask

  // One more cycle with start low: no second done, still idle
  task automatic idle_check(input int sel, input string tag);
    logic [63:0] z;
    logic        c, o, bz, d;
    @(posedge clk); #1;
    sample(sel, z, c, o, bz, d);
    chk($sformatf("%s.idle_done", tag), 64'(d), 64'(0));
    chk($sformatf("%s.idle_busy", tag), 64'(bz), 64'(0));
    chk($sformatf("%s.idle_Z", tag), z, prev_z[sel]);
  endtask

  initial begin
    logic [63:0] z;
    logic        c, o, bz, d;
    for (int k = 0; k < 3; k++) begin
      drive(k, 1'b0, 64'd0, 64'd0, 1'b0);
      prev_z[k] = 64'd0;
    end

    // Reset state
    #2;
    for (int k = 0; k < 3; k++) begin
      sample(k, z, c, o, bz, d);
      chk($sformatf("rst%0d.Z", k), z, 64'd0);
      chk($sformatf("rst%0d.flags", k), {60'd0, c, o, bz, d}, 64'd0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Directed add/sub vectors, issued back-to-back
    run_op(0, 64'h000D, 64'h0006, 1'b0, "add", 0);
    chk_lit(0, "add", 64'h0013, 1'b0, 1'b0);
    idle_check(0, "add");
    run_op(0, 64'hFFFF, 64'h0001, 1'b0, "ripple", 0);
    chk_lit(0, "ripple", 64'h0000, 1'b1, 1'b0);
    run_op(0, 64'h7FFF, 64'h0001, 1'b0, "sovf", 0);
    chk_lit(0, "sovf", 64'h8000, 1'b0, 1'b1);
    run_op(0, 64'h0005, 64'h000D, 1'b1, "sub1", 0);
    chk_lit(0, "sub1", 64'hFFF8, 1'b0, 1'b0);
    run_op(0, 64'h8000, 64'h0001, 1'b1, "sub2", 0);
    chk_lit(0, "sub2", 64'h7FFF, 1'b1, 1'b1);
    idle_check(0, "sub2");

    // start while busy is ignored; exactly one done follows
    run_op(0, 64'h000D, 64'h0006, 1'b0, "ign", 2);
    chk_lit(0, "ign", 64'h0013, 1'b0, 1'b0);
    idle_check(0, "ign");

    // start in the done cycle is accepted
    run_op(0, 64'hAAAA, 64'h5555, 1'b0, "b2b_a", 0);
    run_op(0, 64'h1234, 64'h1111, 1'b0, "b2b_b", 0);
    chk_lit(0, "b2b_b", 64'h2345, 1'b0, 1'b0);

    // Reset after two chunks: outputs clear at once and no done follows
    drive(0, 1'b1, 64'h4321, 64'h1234, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    sample(0, z, c, o, bz, d);
    chk("rstmid.Z", z, 64'd0);
    chk("rstmid.flags", {60'd0, c, o, bz, d}, 64'd0);
    for (int k = 0; k < 3; k++) prev_z[k] = 64'd0;
    @(negedge clk); reset = 1'b0;
    idle_check(0, "rstmid");
    idle_check(0, "rstmid2");
    run_op(0, 64'h00FF, 64'h0001, 1'b0, "postrst", 0);
    chk_lit(0, "postrst", 64'h0100, 1'b0, 1'b0);

    // Single-cycle configuration
    run_op(1, 64'hF0, 64'h20, 1'b0, "w8", 0);
    chk_lit(1, "w8", 64'h10, 1'b1, 1'b0);
    run_op(1, 64'h80, 64'h01, 1'b1, "w8sub", 0);

    // Random traffic against the model
    for (int i = 0; i < 12; i++)
      run_op(0, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
             $sformatf("r16_%0d", i), 0);
    for (int i = 0; i < 30; i++) begin
      run_op(2, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
             $sformatf("r32_%0d", i), (i % 3 == 0) ? 3 : 0);
      if (i % 4 == 1) idle_check(2, $sformatf("r32gap_%0d", i));
    end
    for (int i = 0; i < 8; i++)
      run_op(1, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)),
             $sformatf("r8_%0d", i), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
